// File: rtl/gan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gan_pkg
//  Description : Shared Q8.8 types, layer sizes and FSM state encodings
//  Revision    : 1.0 - initial release
// ============================================================================
package gan_pkg;

    localparam int Q_W      = 16;
    localparam int Q_FRAC   = 8;
    localparam int L3_OUT_N = 128;

    typedef logic signed [Q_W-1:0] q88_t;

    typedef enum logic [0:0] {
        ACT_IDLE   = 1'b0,
        ACT_STREAM = 1'b1
    } act_state_t;

endpackage
`default_nettype wire

// File: rtl/layer3_act_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : layer3_act_streamer_if
//  Description : Element stream (valid/ready) carrying data, index and last
//  Revision    : 1.0 - initial release
// ============================================================================
interface layer3_act_streamer_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 7
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;

    modport master (output valid, output data, output idx, output last, input  ready);
    modport slave  (input  valid, input  data, input  idx, input  last, output ready);
endinterface
`default_nettype wire

// File: rtl/leaky_relu_q88.sv
`default_nettype none
// ============================================================================
//  Module      : leaky_relu_q88
//  Description : Combinational Q8.8 LeakyReLU, negative slope 2^-ALPHA_SHIFT
//  Revision    : 1.0 - initial release
// ============================================================================
module leaky_relu_q88
    import gan_pkg::*;
#(
    parameter int ALPHA_SHIFT = 3
) (
    input  q88_t i_data,
    output q88_t o_data
);

    // Arithmetic shift floors toward -inf; magnitude only shrinks, so no saturation
    assign o_data = i_data[Q_W-1] ? (i_data >>> ALPHA_SHIFT) : i_data;

endmodule
`default_nettype wire

// File: rtl/layer3_act_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : layer3_act_streamer
//  Description : Captures a layer-3 output frame, streams LeakyReLU(x) per beat
//  Revision    : 1.0 - initial release
// ============================================================================
module layer3_act_streamer
    import gan_pkg::*;
#(
    parameter int N_OUT       = L3_OUT_N,
    parameter int DATA_W      = Q_W,
    parameter int ALPHA_SHIFT = 3
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    in_valid,
    output logic                         in_ready,
    input  wire logic [DATA_W*N_OUT-1:0] flat_in,
    layer3_act_streamer_if.master        out_if,
    output logic                         frame_done,
    output logic                         overflow
);

    localparam int                 c_IDX_W    = $clog2(N_OUT);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_OUT - 1);

    act_state_t         r_state;
    act_state_t         w_state_next;
    q88_t               r_buf [N_OUT];
    logic [c_IDX_W-1:0] r_idx;
    logic               r_frame_done;
    logic               r_overflow;

    logic               w_capture;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_last_accept;
    q88_t               w_act;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ACT_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ACT_STREAM;
                end
            end
            ACT_STREAM: begin
                w_out_valid = 1'b1;
                if (out_if.ready && (r_idx == c_LAST_IDX)) begin
                    w_state_next = ACT_IDLE;
                end
            end
            default: w_state_next = ACT_IDLE;
        endcase
    end

    assign w_accept      = w_out_valid && out_if.ready;
    assign w_last_accept = w_accept && (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_capture || w_last_accept) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + c_IDX_W'(1);
        end
    end

    // Buffer is written only on the capture edge; frames arriving mid-stream never touch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_capture) begin
            for (int k = 0; k < N_OUT; k++) begin
                r_buf[k] <= q88_t'(flat_in[k*DATA_W +: DATA_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_last_accept;
            if (in_valid && (r_state == ACT_STREAM)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    leaky_relu_q88 #(
        .ALPHA_SHIFT (ALPHA_SHIFT)
    ) u_act (
        .i_data (r_buf[r_idx]),
        .o_data (w_act)
    );

    assign in_ready     = w_in_ready;
    assign out_if.valid = w_out_valid;
    assign out_if.data  = w_act;
    assign out_if.idx   = r_idx;
    assign out_if.last  = w_out_valid && (r_idx == c_LAST_IDX);
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire
